keypad_scan_input: RTL and testbench
====================================

Name: keypad_scan_input

Overview:
- Scans a 4x4 active-low matrix keypad and produces a one-cycle key strobe with a 4-bit hex code.
- Shifts each accepted key into a 32-bit entry register; the CPU I/O path and the 8-digit display driver both read this register.
- Column drive is a rotating one-hot active-low select from a divided clock tick, mirroring the digit-select scheme on the display side.

Parameters:
- DIV_BITS, 11, scan-tick divider width; scan_tick pulses once every 2^DIV_BITS clk cycles.
- DEBOUNCE_TICKS, 4, consecutive stable scan ticks needed to accept a press or confirm a release (>=1).
- REPEAT_TICKS, 64, held scan ticks between auto-repeat strobes (KEYPAD_REPEAT_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- row_n  in  4  keypad rows, active-low, asynchronous to clk
- col_n  out  4  column drive, one-hot active-low
- clr  in  1  synchronous clear of value
- key_valid  out  1  one-clk strobe on accepted key
- key_code  out  4  code of last accepted key, = row*4 + col
- value  out  32  entry register, newest nibble in [3:0]

Behaviour:
- Interface is decided: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: col_n=4'b1110, key_valid=0, key_code=0, value=0, divider=0, debounce and repeat counters=0, state=SCAN.
- Synchronise row_n through two flops to get rows_s. All decisions use rows_s sampled in the clk cycle where scan_tick=1.
- scan_tick fires when the DIV_BITS divider equals all-ones. The divider wraps freely and runs in every state.
- SCAN:
  - On a tick with rows_s==4'b1111: rotate col_n 1110->1101->1011->0111->1110.
  - On a tick with exactly one row low: latch col index and row index, set db_cnt=1, go to DEBOUNCE. col_n freezes.
  - More than one row low: treat as no key and keep rotating.
  - An illegal col_n value recovers to 1110 on the next tick.
- DEBOUNCE:
  - On a tick with the same single row low: increment db_cnt.
  - When db_cnt reaches DEBOUNCE_TICKS: accept the key and go to HELD.
  - Any other row pattern: go to SCAN and rotate on the next tick.
  - With DEBOUNCE_TICKS=1, acceptance happens on the tick that enters DEBOUNCE; no extra tick is needed.
- Accept:
  - In the cycle after the accepting tick, key_valid=1 for exactly one clk, and key_code is updated in the same cycle.
  - value <= {value[27:0], code}. The top nibble is discarded, so after 8 keys the oldest key is lost.
- HELD:
  - col_n stays frozen.
  - A tick with rows_s==1111 increments rel_cnt.
  - A tick with any row low resets rel_cnt to 0.
  - When rel_cnt reaches DEBOUNCE_TICKS: go to SCAN and rotate on the next tick.
  - A different key pressed while one is held is ignored until release.
- clr has priority over a simultaneous accept: value becomes 0 and the accepted nibble is dropped. key_valid and key_code still update.
- rst mid-operation returns everything to reset values immediately; a key still held after reset is re-debounced from SCAN.
- key_code holds its value between strobes.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, rep_cnt counts ticks while the key stays down.
  - On reaching REPEAT_TICKS, emit another key_valid strobe with the same code, shift value again, and reset rep_cnt to 0.
  - Release or rst clears rep_cnt.
- Undefined: exactly one strobe per press; no rep_cnt logic is synthesised.

Test Plan:
- Reset: assert rst asynchronously mid-tick -> col_n=1110, value=0, key_valid=0 with no clk edge needed.
- Single key (DIV_BITS=2, DEBOUNCE_TICKS=4): hold row 2 low while col_n=1011 (col 2) -> one key_valid pulse, key_code=4'hA, value=32'h0000000A.
- Bounce: toggle row 1 for 2 ticks, then release -> no key_valid, col_n resumes rotating, value unchanged.
- Sequence: enter keys 1,2,3,4,5,6,7,8,9 with full release between each -> value=32'h23456789, exactly 9 strobes.
- Ghost and clear: two rows low together -> no strobe. Then assert clr in the same cycle as an accept of key 5 -> value=0, key_code=5.
- With KEYPAD_REPEAT_EN (REPEAT_TICKS=8): hold key 3 for 4+8+8 ticks -> 3 strobes, value=32'h00000333.

Source files
------------

// File: rtl/keypad_scan_input.sv
// 4x4 active-low matrix keypad scanner: column rotation, debounce, hex strobe and 32-bit entry register.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_scan_input #(
    parameter int DIV_BITS       = 11,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] value
);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    localparam int              DB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
    localparam bit              DB_ONE  = (DEBOUNCE_TICKS == 1);

    logic [1:0]          state;
    logic [DIV_BITS-1:0] divider;
    logic [3:0]          row_meta;
    logic [3:0]          rows_s;
    logic [DB_W-1:0]     db_cnt;
    logic [DB_W-1:0]     rel_cnt;
    logic [3:0]          key_rows;
    logic [3:0]          key_idx;

    logic       scan_tick;
    logic       row_single;
    logic [1:0] row_idx;
    logic       col_legal;
    logic [1:0] col_idx;
    logic [3:0] col_next;
    logic       detect;
    logic       db_done;
    logic       accept;
    logic [3:0] accept_code;
    logic       repeat_fire;

    assign scan_tick = &divider;

    always_comb begin
        row_single = 1'b1;
        row_idx    = 2'd0;
        case (rows_s)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_single = 1'b0;
        endcase
    end

    // An unexpected column pattern steers back to column 0 on the next tick.
    always_comb begin
        col_legal = 1'b1;
        col_idx   = 2'd0;
        col_next  = 4'b1110;
        case (col_n)
            4'b1110: begin col_idx = 2'd0; col_next = 4'b1101; end
            4'b1101: begin col_idx = 2'd1; col_next = 4'b1011; end
            4'b1011: begin col_idx = 2'd2; col_next = 4'b0111; end
            4'b0111: begin col_idx = 2'd3; col_next = 4'b1110; end
            default: col_legal = 1'b0;
        endcase
    end

    assign detect      = scan_tick && (state == SCAN) && col_legal && row_single;
    assign db_done     = scan_tick && (state == DEBOUNCE) && (rows_s == key_rows) && (db_cnt == DB_LAST);
    assign accept      = (detect && DB_ONE) || db_done || repeat_fire;
    assign accept_code = detect ? {row_idx, col_idx} : key_idx;

`ifdef KEYPAD_REPEAT_EN
    localparam int              RP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_TICKS - 1);

    logic [RP_W-1:0] rep_cnt;

    assign repeat_fire = scan_tick && (state == HELD) && (rows_s != 4'b1111) && (rep_cnt == RP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if (scan_tick) begin
            if ((state != HELD) || (rows_s == 4'b1111) || repeat_fire)
                rep_cnt <= '0;
            else
                rep_cnt <= rep_cnt + RP_W'(1);
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // clr is written after the accept shift so it wins when both happen in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            divider   <= '0;
            row_meta  <= 4'b1111;
            rows_s    <= 4'b1111;
            db_cnt    <= '0;
            rel_cnt   <= '0;
            key_rows  <= 4'b1111;
            key_idx   <= 4'd0;
            col_n     <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            value     <= 32'd0;
        end else begin
            divider   <= divider + DIV_BITS'(1);
            row_meta  <= row_n;
            rows_s    <= row_meta;
            key_valid <= accept;
            if (accept) begin
                key_code <= accept_code;
                value    <= {value[27:0], accept_code};
            end
            if (clr)
                value <= 32'd0;

            if (scan_tick) begin
                case (state)
                    SCAN: begin
                        if (!col_legal) begin
                            col_n <= 4'b1110;
                        end else if (row_single) begin
                            key_rows <= rows_s;
                            key_idx  <= {row_idx, col_idx};
                            db_cnt   <= DB_W'(1);
                            rel_cnt  <= '0;
                            state    <= DB_ONE ? HELD : DEBOUNCE;
                        end else begin
                            col_n <= col_next;
                        end
                    end
                    DEBOUNCE: begin
                        if (rows_s == key_rows) begin
                            db_cnt <= db_cnt + DB_W'(1);
                            if (db_cnt == DB_LAST)
                                state <= HELD;
                        end else begin
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (rows_s == 4'b1111) begin
                            if (rel_cnt == DB_LAST) begin
                                rel_cnt <= '0;
                                state   <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + DB_W'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_input.sv
// Randomized scoreboard bench for keypad_scan_input; a keypad model drives rows from the column select.
// Build with KEYPAD_REPEAT_EN defined to also exercise auto-repeat.
module tb_keypad_scan_input;

    localparam int DIV_BITS = 2;
    localparam int DB       = 4;
    localparam int REP      = 8;
    localparam int TICK     = 1 << DIV_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] value;

    logic [15:0] pressed;
    int          errors      = 0;
    int          checks      = 0;
    int          strobes     = 0;
    int          exp_strobes = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;
    logic [31:0] model_value;
    logic [3:0]  model_code;

    keypad_scan_input #(
        .DIV_BITS(DIV_BITS),
        .DEBOUNCE_TICKS(DB),
        .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row_n(row_n),
        .col_n(col_n),
        .clr(clr),
        .key_valid(key_valid),
        .key_code(key_code),
        .value(value)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c])
                    row_n[r] = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got code=%h value=%h, required no strobe", key_code, value);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("strobe_code", 32'(key_code), 32'(mon_e[35:32]));
                checkOutput("strobe_value", value, mon_e[31:0]);
            end
        end
    end

    // Presses mask for exactly nticks scan ticks, starting just after the scan reaches column col.
    task automatic applyStimulus(input logic [15:0] mask, input int col, input int nticks, input bit use_clr);
        logic [3:0] prev;
        logic [3:0] code;
        bit         found;
        int         n_rep;
        found = 1'b0;
        prev  = col_n;
        for (int i = 0; i < 40 * TICK && !found; i++) begin
            @(negedge clk);
            if (col_n != prev && col_n == ~(4'b0001 << col))
                found = 1'b1;
            prev = col_n;
        end
        if (!found) begin
            checkOutput("align_timeout", 32'(col_n), 32'(~(4'b0001 << col)));
            return;
        end
        if ($countones(mask) == 1 && nticks >= DB) begin
            code  = 4'd0;
            n_rep = 0;
            for (int i = 0; i < 16; i++)
                if (mask[i]) code = 4'(i);
`ifdef KEYPAD_REPEAT_EN
            n_rep = (nticks - DB) / REP;
`endif
            for (int k = 0; k <= n_rep; k++) begin
                model_value = (use_clr && k == 0) ? 32'd0 : {model_value[27:0], code};
                model_code  = code;
                exp_q.push_back({code, model_value});
                exp_strobes++;
            end
        end
        pressed = mask;
        for (int i = 0; i < TICK * nticks; i++) begin
            clr = use_clr && (i == TICK * DB - 1);
            @(negedge clk);
        end
        clr     = 1'b0;
        pressed = 16'd0;
        repeat (TICK * 6) @(negedge clk);
    endtask

    task automatic checkRotation();
        logic [3:0] prev;
        int         changes;
        prev    = col_n;
        changes = 0;
        repeat (TICK * 6) begin
            @(negedge clk);
            if (col_n != prev) begin
                checkOutput("col_rotate", 32'(col_n), 32'({prev[2:0], prev[3]}));
                changes++;
                prev = col_n;
            end
        end
        checkOutput("col_moving", 32'(changes >= 4), 32'd1);
    endtask

    initial begin
        int base;
        int code;
        int n;
        rst         = 1'b1;
        clr         = 1'b0;
        pressed     = 16'd0;
        model_value = 32'd0;
        model_code  = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_col", 32'(col_n), 32'h0000000E);
        checkOutput("reset_value", value, 32'd0);
        checkOutput("reset_valid", 32'(key_valid), 32'd0);
        checkOutput("reset_code", 32'(key_code), 32'd0);
        rst = 1'b0;

        applyStimulus(16'(1) << 10, 2, 6, 1'b0);
        checkOutput("single_value", value, 32'h0000000A);
        checkOutput("single_code", 32'(key_code), 32'h0000000A);

        applyStimulus(16'(1) << 5, 1, 2, 1'b0);
        applyStimulus(16'(1) << 6, 2, 3, 1'b0);
        checkOutput("bounce_value", value, 32'h0000000A);
        checkRotation();

        base = strobes;
        for (int k = 1; k <= 9; k++)
            applyStimulus(16'(1) << k, k % 4, 6, 1'b0);
        checkOutput("seq_value", value, 32'h23456789);
        checkOutput("seq_strobes", 32'(strobes - base), 32'd9);

        applyStimulus((16'(1) << 1) | (16'(1) << 13), 1, 6, 1'b0);
        checkOutput("ghost_value", value, 32'h23456789);

        applyStimulus(16'(1) << 5, 1, 6, 1'b1);
        checkOutput("clr_value", value, 32'd0);
        checkOutput("clr_code", 32'(key_code), 32'd5);

        for (int k = 0; k < 12; k++) begin
            code = int'($urandom_range(0, 15));
            n    = int'($urandom_range(2, 6));
            applyStimulus(16'(1) << code, code % 4, n, 1'b0);
            checkOutput("rand_value", value, model_value);
        end
        checkOutput("code_hold", 32'(key_code), 32'(model_code));

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_col", 32'(col_n), 32'h0000000E);
        checkOutput("midreset_value", value, 32'd0);
        checkOutput("midreset_valid", 32'(key_valid), 32'd0);
        checkOutput("midreset_code", 32'(key_code), 32'd0);
        model_value = 32'd0;
        model_code  = 4'd0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

`ifdef KEYPAD_REPEAT_EN
        base = strobes;
        applyStimulus(16'(1) << 3, 3, DB + 2 * REP, 1'b0);
        checkOutput("repeat_value", value, 32'h00000333);
        checkOutput("repeat_strobes", 32'(strobes - base), 32'd3);
`endif

        applyStimulus(16'(1) << 15, 3, 5, 1'b0);
        checkOutput("post_reset_value", value, model_value);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("strobe_count", 32'(strobes), 32'(exp_strobes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
